// File: rtl/cfu_mac_initiator.sv
// CPU-side initiator for the CFU cmd/rsp handshake: runs one CLEAR command, then N MAC commands, and returns the final accumulator.
// Only one command is outstanding at a time, and a watchdog bounds the wait for each response.
module cfu_mac_initiator #(
    parameter int unsigned LEN_W      = 16,
    parameter logic [9:0]  FUNC_CLEAR = 10'h008,
    parameter logic [9:0]  FUNC_MAC4  = 10'h000,
    parameter logic [9:0]  FUNC_MAC1  = 10'h001,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [LEN_W-1:0] job_len,
    input  logic             job_simd,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [31:0]      op_input,
    input  logic [31:0]      op_filter,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [9:0]       cmd_payload_function_id,
    output logic [31:0]      cmd_payload_inputs_0,
    output logic [31:0]      cmd_payload_inputs_1,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic [31:0]      rsp_payload_outputs_0,
    input  logic             rsp_payload_response_ok,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_err,
    output logic             busy
);
    localparam int unsigned      TMR_W    = $clog2(TIMEOUT + 1);
    // The timer reaches TIMEOUT-1 on the edge where it leaves TIMEOUT-2.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR_CMD,
        S_CLR_RSP,
        S_FETCH,
        S_MAC_CMD,
        S_MAC_RSP,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_cmd_valid;
    logic [9:0]        r_func;
    logic [31:0]       r_in0;
    logic [31:0]       r_in1;
    logic              r_res_valid;
    logic [31:0]       r_res_data;
    logic              r_err;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_simd;
    logic [TMR_W-1:0]  r_timer;

    logic w_in_rsp;
    logic w_rsp_fire;
    logic w_timeout;
    logic w_cmd_fire;
    logic w_op_fire;
    logic w_job_fire;
    logic w_res_fire;
    logic w_last;

    always_comb begin
        w_in_rsp   = (r_state == S_CLR_RSP) || (r_state == S_MAC_RSP);
        w_rsp_fire = w_in_rsp && rsp_valid;
        w_timeout  = w_in_rsp && !rsp_valid && (r_timer == TMR_LAST);
        w_cmd_fire = r_cmd_valid && cmd_ready;
        w_op_fire  = (r_state == S_FETCH) && op_valid;
        w_job_fire = (r_state == S_IDLE) && job_valid;
        w_res_fire = (r_state == S_DONE) && r_res_valid && res_ready;
        // A MAC response retires one command, so the job ends when the last one returns.
        w_last     = (r_state == S_MAC_RSP) ? (r_remaining == LEN_W'(1))
                                            : (r_remaining == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_job_fire) w_state_nxt = S_CLR_CMD;
            S_CLR_CMD: if (w_cmd_fire) w_state_nxt = S_CLR_RSP;
            S_MAC_CMD: if (w_cmd_fire) w_state_nxt = S_MAC_RSP;
            S_CLR_RSP,
            S_MAC_RSP: begin
                if (w_rsp_fire) begin
                    w_state_nxt = w_last ? S_DONE : S_FETCH;
                end else if (w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_FETCH:   if (w_op_fire) w_state_nxt = S_MAC_CMD;
            S_DONE:    if (w_res_fire) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_valid <= 1'b0;
            r_func      <= '0;
            r_in0       <= '0;
            r_in1       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_err       <= 1'b0;
            r_remaining <= '0;
            r_simd      <= 1'b0;
            r_timer     <= '0;
        end else begin
            if (w_job_fire) begin
                r_remaining <= job_len;
                r_simd      <= job_simd;
                r_err       <= 1'b0;
                r_func      <= FUNC_CLEAR;
                r_in0       <= '0;
                r_in1       <= '0;
                r_cmd_valid <= 1'b1;
            end
            if (w_op_fire) begin
                r_in0       <= op_input;
                r_in1       <= op_filter;
                r_func      <= r_simd ? FUNC_MAC4 : FUNC_MAC1;
                r_cmd_valid <= 1'b1;
            end
            if (w_cmd_fire) begin
                r_cmd_valid <= 1'b0;
                r_timer     <= '0;
            end else if (w_in_rsp) begin
                r_timer <= r_timer + TMR_W'(1);
            end
            if (w_rsp_fire) begin
                r_err      <= r_err | ~rsp_payload_response_ok;
                r_res_data <= rsp_payload_outputs_0;
                if (r_state == S_MAC_RSP) begin
                    r_remaining <= r_remaining - LEN_W'(1);
                end
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if ((w_rsp_fire && w_last) || w_timeout) begin
                r_res_valid <= 1'b1;
            end
            if (w_res_fire) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign job_ready               = (r_state == S_IDLE);
    assign busy                    = (r_state != S_IDLE);
    assign op_ready                = (r_state == S_FETCH);
    assign rsp_ready               = (r_state == S_IDLE) || w_in_rsp;
    assign cmd_valid               = r_cmd_valid;
    assign cmd_payload_function_id = r_func;
    assign cmd_payload_inputs_0    = r_in0;
    assign cmd_payload_inputs_1    = r_in1;
    assign res_valid               = r_res_valid;
    assign res_data                = r_res_data;
    assign res_err                 = r_err;

endmodule

// File: tb/tb_cfu_mac_initiator.sv
// Bench for cfu_mac_initiator: a behavioural CFU, an operand source and a result sink, plus per-scenario tasks.
`timescale 1ns/1ps
module tb_cfu_mac_initiator;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [15:0] job_len = '0;
    logic        job_simd = 1'b0;
    logic        op_valid, op_ready;
    logic [31:0] op_input, op_filter;
    logic        cmd_valid, cmd_ready;
    logic [9:0]  fid;
    logic [31:0] in0, in1;
    logic        rsp_valid, rsp_ready, rsp_ok;
    logic [31:0] rsp_dat;
    logic        res_valid, res_ready, res_err, busy;
    logic [31:0] res_data;

    always #5 clk = ~clk;

    cfu_mac_initiator #(.LEN_W(16), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len), .job_simd(job_simd),
        .op_valid(op_valid), .op_ready(op_ready), .op_input(op_input), .op_filter(op_filter),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_payload_function_id(fid),
        .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_dat),
        .rsp_payload_response_ok(rsp_ok),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .busy(busy)
    );

    typedef struct packed { logic [31:0] data; logic err; } exp_t;

    int   checks = 0, errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    logic [63:0] op_q[$];
    logic [9:0]  cmd_log[$];

    bit          stalls_en = 0, long_dly = 0, bad_ok = 0, cfu_pend = 0, cfu_muted = 0;
    int          cfu_dly = 0, cmd_stall = 0, mute_at = -1, cmd_total = 0, hs_cyc = 0;
    logic [31:0] cfu_acc = '0, cfu_rsp = '0;
    int          op_stall = 0, ops_used = 0;
    int          res_stall = 0, res_count = 0, first_res_cyc = 0, res_vld_cycles = 0;
    bit          res_prev = 0;
    logic [31:0] got_data;
    logic        got_err;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference CFU arithmetic: activations carry a +128 input offset.
    function automatic logic [31:0] mac_step(logic [31:0] acc, logic [9:0] f,
                                             logic [31:0] a, logic [31:0] w);
        logic [31:0] r;
        int av, wv, lanes;
        if (f == 10'h008) return 32'd0;
        r = acc;
        lanes = (f == 10'h000) ? 4 : 1;
        for (int i = 0; i < lanes; i++) begin
            av = $signed(a[8*i +: 8]);
            wv = $signed(w[8*i +: 8]);
            r  = r + 32'((av + 128) * wv);
        end
        return r;
    endfunction

    // CFU model: drives after the edge, updates its state at the falling edge.
    initial begin
        cmd_ready = 0; rsp_valid = 0; rsp_dat = '0; rsp_ok = 1;
        forever begin
            @(posedge clk); #1;
            cmd_ready = !cfu_pend && (cmd_stall == 0);
            rsp_valid = cfu_pend && (cfu_dly == 0) && !cfu_muted;
            rsp_dat   = rsp_valid ? cfu_rsp : 32'hDEAD_BEEF;
            rsp_ok    = !bad_ok;
            @(negedge clk);
            if (reset) begin
                cfu_pend = 0; cfu_muted = 0; cmd_stall = 0; cfu_dly = 0;
            end else begin
                if (rsp_valid && rsp_ready) cfu_pend = 0;
                else if (cfu_pend && cfu_dly > 0) cfu_dly--;
                if (cmd_valid && cmd_ready) begin
                    cmd_log.push_back(fid);
                    cfu_acc  = mac_step(cfu_acc, fid, in0, in1);
                    cfu_rsp  = cfu_acc;
                    cfu_pend = 1;
                    cfu_dly  = long_dly ? 10 : (stalls_en ? int'($urandom_range(0, 7)) : 0);
                    if (cmd_total == mute_at) begin
                        cfu_muted = 1;
                        hs_cyc    = cyc + 1;
                    end
                    cmd_total++;
                    cmd_stall = stalls_en ? int'($urandom_range(0, 7)) : 0;
                end else if (cmd_stall > 0) begin
                    cmd_stall--;
                end
            end
        end
    end

    initial begin
        op_valid = 0; op_input = '0; op_filter = '0;
        forever begin
            @(posedge clk); #1;
            op_valid = (op_q.size() > 0) && (op_stall == 0);
            if (op_valid) {op_input, op_filter} = op_q[0];
            @(negedge clk);
            if (reset) begin
                op_q.delete(); op_stall = 0;
            end else if (op_valid && op_ready) begin
                void'(op_q.pop_front());
                ops_used++;
                op_stall = stalls_en ? int'($urandom_range(0, 7)) : 0;
            end else if (op_stall > 0) begin
                op_stall--;
            end
        end
    end

    initial begin
        res_ready = 0;
        forever begin
            @(posedge clk); #1;
            res_ready = (res_stall == 0);
            @(negedge clk);
            if (res_valid && !res_prev) first_res_cyc = cyc;
            res_prev = res_valid;
            if (res_valid) res_vld_cycles++;
            if (!reset && res_valid && res_ready) begin
                got_data = res_data; got_err = res_err; res_count++;
                res_stall = stalls_en ? int'($urandom_range(0, 7)) : 0;
            end else if (res_stall > 0) begin
                res_stall--;
            end
        end
    end

    // Continuous protocol checks: stalled commands stay put, responses are refused while fetching.
    logic        prev_stall = 0;
    logic [73:0] prev_pl = '0;
    always @(negedge clk) begin
        if (!reset && prev_stall) begin
            checks++;
            if (cmd_valid !== 1'b1 || {fid, in0, in1} !== prev_pl) begin
                errors++;
                $display("FAIL payload_stable: got vld=%b pl=%h, want vld=1 pl=%h", cmd_valid, {fid, in0, in1}, prev_pl);
            end
        end
        prev_stall = !reset && cmd_valid && !cmd_ready;
        prev_pl    = {fid, in0, in1};
        if (!reset && op_ready) begin
            checks++;
            if (rsp_ready !== 1'b0) begin
                errors++;
                $display("FAIL rsp_ready_in_fetch: got %b, want 0", rsp_ready);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench watchdog expired");
    end

    task automatic start_job(input int len, input bit simd);
        @(negedge clk);
        job_valid = 1; job_len = 16'(len); job_simd = simd;
        for (int i = 0; i < 200 && !job_ready; i++) @(negedge clk);
        @(negedge clk);
        job_valid = 0;
    endtask

    task automatic wait_result(input int n0, output bit got);
        got = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (res_count > n0) begin got = 1; break; end
        end
    endtask

    task automatic test_reset;
        logic [111:0] obs;
        reset = 1;
        repeat (3) @(negedge clk);
        obs = {cmd_valid, op_ready, res_valid, res_err, busy, job_ready, res_data, fid, in0, in1};
        checks++;
        if (obs !== {6'b000001, 106'd0}) begin
            errors++;
            $display("FAIL reset_values: got %h, want %h", obs, {6'b000001, 106'd0});
        end
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_simd;
        int n0 = res_count; bit got; exp_t e;
        cmd_log.delete(); ops_used = 0;
        op_q.push_back({32'h81818181, 32'h02020202});
        op_q.push_back({32'h81818181, 32'h02020202});
        exp_q.push_back('{data: 32'd16, err: 1'b0});
        start_job(2, 1);
        wait_result(n0, got);
        e = exp_q.pop_front();
        checks++;
        if (!got) begin errors++; $display("FAIL simd_result_timeout: got no result, want one"); end
        checks++;
        if (got_data !== e.data || got_err !== e.err) begin
            errors++; $display("FAIL simd_result: got %h/%b, want %h/%b", got_data, got_err, e.data, e.err);
        end
        checks++;
        if (cmd_log.size() != 3 || cmd_log[0] !== 10'h008 || cmd_log[1] !== 10'h000 || cmd_log[2] !== 10'h000) begin
            errors++; $display("FAIL simd_cmds: got %0d cmds, want 008,000,000", cmd_log.size());
        end
        checks++;
        if (ops_used != 2) begin errors++; $display("FAIL simd_ops: got %0d, want 2", ops_used); end
    endtask

    task automatic test_single;
        int n0 = res_count; bit got; exp_t e;
        cmd_log.delete();
        op_q.push_back({32'h000000FF, 32'h00000003});
        exp_q.push_back('{data: 32'h17D, err: 1'b0});
        start_job(1, 0);
        wait_result(n0, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || got_data !== e.data || got_err !== e.err) begin
            errors++; $display("FAIL single_result: got %h/%b (seen=%0d), want %h/%b", got_data, got_err, got, e.data, e.err);
        end
        checks++;
        if (cmd_log.size() != 2 || cmd_log[0] !== 10'h008 || cmd_log[1] !== 10'h001) begin
            errors++; $display("FAIL single_cmds: got %0d cmds, want 008,001", cmd_log.size());
        end
    endtask

    task automatic test_len0;
        int n0 = res_count; bit got; exp_t e;
        cmd_log.delete(); ops_used = 0;
        exp_q.push_back('{data: 32'd0, err: 1'b0});
        start_job(0, 1);
        wait_result(n0, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || got_data !== e.data || got_err !== e.err) begin
            errors++; $display("FAIL len0_result: got %h/%b (seen=%0d), want %h/%b", got_data, got_err, got, e.data, e.err);
        end
        checks++;
        if (cmd_log.size() != 1 || cmd_log[0] !== 10'h008 || ops_used != 0) begin
            errors++; $display("FAIL len0_cmds: got %0d cmds %0d ops, want 1 cmd 0 ops", cmd_log.size(), ops_used);
        end
    endtask

    task automatic test_random_stalls;
        int n0 = res_count; bit got, ok; exp_t e; logic [31:0] acc, a, w;
        cmd_log.delete(); ops_used = 0; stalls_en = 1;
        acc = '0;
        for (int i = 0; i < 5; i++) begin
            a = $urandom; w = $urandom;
            op_q.push_back({a, w});
            acc = mac_step(acc, 10'h000, a, w);
        end
        exp_q.push_back('{data: acc, err: 1'b0});
        start_job(5, 1);
        // A second job offered while busy must be ignored.
        job_len = 16'd9;
        for (int i = 0; i < 6; i++) begin @(negedge clk); job_valid = busy; end
        job_valid = 0;
        wait_result(n0, got);
        stalls_en = 0;
        e = exp_q.pop_front();
        checks++;
        if (!got || got_data !== e.data || got_err !== e.err) begin
            errors++; $display("FAIL stall_result: got %h/%b (seen=%0d), want %h/%b", got_data, got_err, got, e.data, e.err);
        end
        checks++;
        if (ops_used != 5) begin errors++; $display("FAIL stall_ops: got %0d, want 5", ops_used); end
        ok = (cmd_log.size() == 6) && (cmd_log[0] === 10'h008);
        for (int i = 1; i < cmd_log.size(); i++) if (cmd_log[i] !== 10'h000) ok = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_cmds: got %0d cmds, want 6 (008 then 5x000)", cmd_log.size()); end
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_count != n0 + 1) begin
            errors++; $display("FAIL busy_job_ignored: got busy=%b results=%0d, want 0/%0d", busy, res_count, n0 + 1);
        end
    endtask

    task automatic test_timeout;
        int n0 = res_count; bit got; exp_t e; logic [31:0] acc, a, w;
        ops_used = 0; acc = '0;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; w = $urandom;
            op_q.push_back({a, w});
            if (i < 2) acc = mac_step(acc, 10'h000, a, w);
        end
        exp_q.push_back('{data: acc, err: 1'b1});
        mute_at = cmd_total + 3;
        start_job(4, 1);
        wait_result(n0, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || got_data !== e.data || got_err !== e.err) begin
            errors++; $display("FAIL timeout_result: got %h/%b (seen=%0d), want %h/%b", got_data, got_err, got, e.data, e.err);
        end
        checks++;
        if (first_res_cyc - hs_cyc != 15) begin
            errors++; $display("FAIL timeout_latency: got %0d cycles, want 15", first_res_cyc - hs_cyc);
        end
        checks++;
        if (ops_used != 3) begin errors++; $display("FAIL timeout_ops: got %0d, want 3", ops_used); end
        @(negedge clk);
        op_q.delete();
        mute_at = -1; cfu_muted = 0;
        for (int i = 0; i < 20 && cfu_pend; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (cfu_pend !== 1'b0 || res_count != n0 + 1 || busy !== 1'b0 || res_data !== acc) begin
            errors++;
            $display("FAIL late_rsp_drain: got pend=%b results=%0d busy=%b data=%h, want 0/%0d/0/%h",
                     cfu_pend, res_count, busy, res_data, n0 + 1, acc);
        end
    endtask

    task automatic test_bad_ok;
        int n0 = res_count; bit got; exp_t e; logic [31:0] a, w;
        a = 32'h0000_0010; w = 32'h0000_0005;
        op_q.push_back({a, w});
        exp_q.push_back('{data: mac_step(32'd0, 10'h001, a, w), err: 1'b1});
        bad_ok = 1;
        start_job(1, 0);
        wait_result(n0, got);
        bad_ok = 0;
        e = exp_q.pop_front();
        checks++;
        if (!got || got_data !== e.data || got_err !== e.err) begin
            errors++; $display("FAIL bad_ok_result: got %h/%b (seen=%0d), want %h/%b", got_data, got_err, got, e.data, e.err);
        end
    endtask

    task automatic test_reset_mid;
        int n0 = res_count, v0; bit got, hit; exp_t e; logic [111:0] obs;
        cmd_log.delete(); long_dly = 1; hit = 0;
        for (int i = 0; i < 3; i++) op_q.push_back({$urandom, $urandom});
        start_job(3, 1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_log.size() >= 2 && cfu_pend && rsp_ready && busy) begin hit = 1; break; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL reset_mid_reach: got no MAC_RSP wait, want one"); end
        v0 = res_vld_cycles;
        reset = 1;
        @(negedge clk);
        obs = {cmd_valid, op_ready, res_valid, res_err, busy, job_ready, res_data, fid, in0, in1};
        checks++;
        if (obs !== {6'b000001, 106'd0}) begin
            errors++; $display("FAIL reset_mid_values: got %h, want %h", obs, {6'b000001, 106'd0});
        end
        @(negedge clk);
        reset = 0; long_dly = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (res_vld_cycles != v0 || res_count != n0) begin
            errors++; $display("FAIL reset_mid_no_result: got %0d vld cycles %0d results, want 0 and %0d", res_vld_cycles - v0, res_count, n0);
        end
        cmd_log.delete();
        op_q.push_back({32'h0000007F, 32'h000000FE});
        exp_q.push_back('{data: mac_step(32'd0, 10'h001, 32'h0000007F, 32'h000000FE), err: 1'b0});
        start_job(1, 0);
        wait_result(n0, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || got_data !== e.data || got_err !== e.err) begin
            errors++; $display("FAIL reset_mid_new_job: got %h/%b (seen=%0d), want %h/%b", got_data, got_err, got, e.data, e.err);
        end
        checks++;
        if (cmd_log.size() != 2 || cmd_log[0] !== 10'h008 || cmd_log[1] !== 10'h001) begin
            errors++; $display("FAIL reset_mid_cmds: got %0d cmds, want 008,001", cmd_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_simd();
        test_single();
        test_len0();
        test_random_stalls();
        test_timeout();
        test_bad_ok();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfu_mac_initiator.md
Name: cfu_mac_initiator

Overview:
- Initiator (CPU-side) end of the CFU cmd/rsp handshake, used by the KWS accelerator datapath and the bench harness.
- Accepts a MAC job, then issues one CLEAR command followed by N MAC commands with operands from a valid/ready operand stream.
- Returns the CFU's final accumulator value on a result port.
- Keeps at most one command outstanding and has a per-response timeout watchdog.

Parameters:
- LEN_W, 16, width of job_len.
- FUNC_CLEAR, 10'h008, function_id for the accumulator-clear command (bit 3 set).
- FUNC_MAC4, 10'h000, function_id for the 4-lane SIMD MAC.
- FUNC_MAC1, 10'h001, function_id for the single-lane MAC (lane 0 only).
- TIMEOUT, 256, maximum cycles to wait for rsp_valid after a command handshake; must be at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- job_valid  in  1  job request
- job_ready  out  1  high only in IDLE
- job_len  in  LEN_W  number of MAC commands (0 allowed)
- job_simd  in  1  1 selects FUNC_MAC4, 0 selects FUNC_MAC1
- op_valid  in  1  operand pair available
- op_ready  out  1  operand accept
- op_input  in  32  packed int8 activations, driven to cmd_payload_inputs_0
- op_filter  in  32  packed int8 weights, driven to cmd_payload_inputs_1
- cmd_valid  out  1  command to CFU
- cmd_ready  in  1  CFU accepts command
- cmd_payload_function_id  out  10  CFU function select
- cmd_payload_inputs_0  out  32  rs1 operand
- cmd_payload_inputs_1  out  32  rs2 operand
- rsp_valid  in  1  CFU response valid
- rsp_ready  out  1  response accept
- rsp_payload_outputs_0  in  32  CFU accumulator value
- rsp_payload_response_ok  in  1  CFU status
- res_valid  out  1  job result valid
- res_ready  in  1  result accept
- res_data  out  32  final accumulator value
- res_err  out  1  timeout occurred or a response had response_ok=0
- busy  out  1  state is not IDLE

Behaviour:
- Reset values: cmd_valid=0, op_ready=0, res_valid=0, res_data=0, res_err=0, function_id/inputs=0, state=IDLE, counters=0.
- Registered outputs: cmd_* and res_*.
- Combinational outputs: job_ready, op_ready, rsp_ready, busy, all decoded from state.
- States: IDLE, CLR_CMD, CLR_RSP, FETCH, MAC_CMD, MAC_RSP, DONE.
- IDLE:
  - job_ready=1 and rsp_ready=1; stale responses are drained and discarded.
  - On job_valid: latch job_len and job_simd, set remaining=job_len, clear the error flag, load function_id=FUNC_CLEAR and inputs=0, assert cmd_valid, go to CLR_CMD.
- CLR_CMD / MAC_CMD:
  - cmd_valid held high with payload stable until cmd_ready.
  - On the cycle cmd_valid&cmd_ready, drop cmd_valid, zero the timer, go to the matching *_RSP state.
  - No timeout applies while waiting for cmd_ready.
- CLR_RSP / MAC_RSP:
  - rsp_ready=1 and the timer increments each cycle.
  - On rsp_valid: OR ~response_ok into the error flag and capture outputs_0 into res_data.
  - From CLR_RSP on rsp_valid: go to DONE if remaining==0, else FETCH.
  - From MAC_RSP on rsp_valid: decrement remaining, then go to DONE if it reaches 0, else FETCH.
  - If the timer reaches TIMEOUT-1 without rsp_valid: set the error flag, go to DONE; res_data keeps its last captured value.
- FETCH:
  - op_ready=1.
  - On op_valid: latch op_input/op_filter into inputs_0/1, set function_id=(job_simd ? FUNC_MAC4 : FUNC_MAC1), assert cmd_valid next cycle, go to MAC_CMD.
  - Exactly one operand pair is consumed per MAC command.
- DONE:
  - res_valid=1, res_err=error flag, both held until res_ready.
  - On the cycle res_valid&res_ready: res_valid→0, go to IDLE.
  - job_ready stays 0 throughout DONE.
- Latency:
  - Command-to-command spacing is 1 cycle of CMD, then ≥1 cycle of RSP, then 1 cycle of FETCH when the operand stream is always valid.
  - At zero wait states the overhead is ≥3 cycles per MAC.
- Boundaries:
  - job_len=0: CLEAR only; res_data = clear response (0 from a conforming CFU).
  - job_len=2^LEN_W-1: the counter must not wrap.
  - rsp_valid in the same cycle the timer hits TIMEOUT-1: the response wins, no error.
  - job_valid while busy: ignored.
  - rsp_valid outside IDLE/*_RSP (e.g. during FETCH): ignored with rsp_ready=0.
  - Reset mid-job: immediate return to reset values, with no partial result emitted.
- Arithmetic: none local. res_data is passed through from the CFU unmodified; accumulation lives in the CFU.

Test Plan:
- SIMD job, len=2, both words input=0x81818181, filter=0x02020202, CFU model zero-wait → commands 0x008, 0x000, 0x000; res_data=16 (0x10), res_err=0.
- Single-lane job, len=1, input=0x000000FF, filter=0x00000003 → function_id 0x001; res_data=381 (0x17D).
- len=0 → exactly one CLEAR command, zero operands consumed, res_data=0, res_valid asserted after the CLEAR response.
- Random cmd_ready, rsp_valid, op_valid and res_ready stalls (0–7 cycles), len=5 → payload stable while cmd_valid&~cmd_ready; exactly 5 operands consumed; result matches the CFU model.
- CFU stops responding after the 2nd MAC, TIMEOUT=16 → DONE reached 15 cycles after the handshake, res_err=1, res_data = 2nd MAC's response; a late rsp_valid is drained in IDLE.
- Reset asserted during MAC_RSP, then a new len=1 job → all outputs back at reset values next cycle, no res_valid pulse, new job completes correctly.
